// File: rtl/seq_sender.sv
// rtl/seq_sender.sv - transmit side of the ASCII sequence link
//
// Purpose: on a start pulse, offers a fixed sequence of SEQ_LEN seven-bit
// characters (CHAR0..CHAR3) one at a time over a valid/ready handshake,
// optionally separated by GAP idle cycles, then pulses done for one cycle.
//
// Ports:
//   clk         in   1  clock, all state changes on posedge
//   reset       in   1  synchronous, active-high
//   start       in   1  request one sequence, sampled only in IDLE
//   ready       in   1  sink accepts the current character when valid && ready
//   ascii       out  7  current character, 0 whenever valid is 0
//   valid       out  1  ascii holds a character offered to the sink
//   busy        out  1  high from the cycle after an accepted start until DONE
//   done        out  1  one-cycle pulse after the last character transferred
//   sent_count  out  8  completed sequences, wraps 255 -> 0
//
// Parameters: SEQ_LEN is legal in 1..4, GAP in 0..15.

module seq_sender #(
    parameter int         SEQ_LEN = 3,
    parameter logic [6:0] CHAR0   = 7'h31,
    parameter logic [6:0] CHAR1   = 7'h32,
    parameter logic [6:0] CHAR2   = 7'h33,
    parameter logic [6:0] CHAR3   = 7'h34,
    parameter int         GAP     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ready,
    output logic [6:0] ascii,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] sent_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP_WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] LAST_IDX  = 2'(SEQ_LEN - 1);
    // Loaded on entry to the gap state; the gap ends when it has counted down
    // to zero, which gives exactly GAP cycles with valid low.
    localparam logic [3:0] GAP_START = 4'(GAP - 1);

    state_t     state, state_n;
    logic [1:0] index, index_n;
    logic [3:0] gap_cnt, gap_cnt_n;
    logic [6:0] ascii_n;
    logic       valid_n;
    logic       busy_n;
    logic       done_n;
    logic [7:0] sent_count_n;

    function automatic logic [6:0] char_at(input logic [1:0] idx);
        case (idx)
            2'd0:    return CHAR0;
            2'd1:    return CHAR1;
            2'd2:    return CHAR2;
            default: return CHAR3;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            index      <= 2'd0;
            gap_cnt    <= 4'd0;
            ascii      <= 7'h00;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= 8'd0;
        end else begin
            state      <= state_n;
            index      <= index_n;
            gap_cnt    <= gap_cnt_n;
            ascii      <= ascii_n;
            valid      <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
            sent_count <= sent_count_n;
        end
    end

    // Every output is computed here as its next registered value; holding the
    // current value is the default so backpressure leaves ascii/valid stable.
    always_comb begin
        state_n      = state;
        index_n      = index;
        gap_cnt_n    = gap_cnt;
        ascii_n      = ascii;
        valid_n      = valid;
        busy_n       = busy;
        done_n       = 1'b0;
        sent_count_n = sent_count;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SEND;
                    index_n = 2'd0;
                    ascii_n = char_at(2'd0);
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end

            SEND: begin
                if (valid && ready) begin
                    if (index == LAST_IDX) begin
                        state_n      = DONE;
                        ascii_n      = 7'h00;
                        valid_n      = 1'b0;
                        busy_n       = 1'b0;
                        done_n       = 1'b1;
                        sent_count_n = sent_count + 8'd1;
                    end else if (GAP == 0) begin
                        index_n = index + 2'd1;
                        ascii_n = char_at(index + 2'd1);
                    end else begin
                        state_n   = GAP_WAIT;
                        gap_cnt_n = GAP_START;
                        ascii_n   = 7'h00;
                        valid_n   = 1'b0;
                    end
                end
            end

            GAP_WAIT: begin
                if (gap_cnt == 4'd0) begin
                    state_n = SEND;
                    index_n = index + 2'd1;
                    ascii_n = char_at(index + 2'd1);
                    valid_n = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt - 4'd1;
                end
            end

            DONE: begin
                // start is deliberately ignored here; it is only sampled in IDLE.
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
